// File: rtl/maze_player_ctrl.sv
// Maze player movement controller: button sync/repeat, wall checks,
// move counting and goal lock on a COLS x ROWS grid.
module maze_player_ctrl #(
   parameter int COLS          = 6,
   parameter int ROWS          = 5,
   parameter int POS_W         = 5,
   parameter int START_POS     = 0,
   parameter int GOAL_POS      = 29,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int REPEAT_CYCLES = 12500000,
   parameter int CNT_W         = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        btnU,
   input  logic                        btnD,
   input  logic                        btnL,
   input  logic                        btnR,
   input  logic                        enable,
   input  logic                        restart,
   input  logic [ROWS*(COLS-1)-1:0]    walls_h,
   input  logic [(ROWS-1)*COLS-1:0]    walls_v,
   output logic [POS_W-1:0]            position,
   output logic [$clog2(ROWS)-1:0]     row,
   output logic [$clog2(COLS)-1:0]     col,
   output logic [1:0]                  direction,
   output logic                        moved,
   output logic                        bumped,
   output logic                        at_goal,
   output logic [CNT_W-1:0]            move_count
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int HW = $clog2(ROWS*(COLS-1));
   localparam int VW = $clog2((ROWS-1)*COLS);
   localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW = $clog2(TMAX + 1);
   localparam int START_ROW = START_POS / COLS;
   localparam int START_COL = START_POS % COLS;
   localparam int GOAL_ROW  = GOAL_POS / COLS;
   localparam int GOAL_COL  = GOAL_POS % COLS;

   typedef enum logic [1:0] {IDLE, EVAL, LOCKED} state_t;

   state_t            state, state_n;
   logic [3:0]        s1, s2, s3, press, rep, cmd;
   logic [2:0]        sel, sel_q;
   logic [TW-1:0]     cnt, cur;
   logic              phase, ph, same, fire;
   logic [1:0]        cmd_dir, cap_dir, cap_n, dir_n;
   logic [RW-1:0]     row_n, mv_row;
   logic [CW-1:0]     col_n, mv_col;
   logic              moved_n, bumped_n, blocked;
   logic [CNT_W-1:0]  cnt_n;
   logic [VW-1:0]     vu, vd;
   logic [HW-1:0]     hl, hr;

   // Button order in the vectors is U, D, L, R (bit 0..3)
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= {btnR, btnL, btnD, btnU};
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign press = s2 & ~s3;

   always_comb begin
      sel = 3'd0;
      if (s2[0])      sel = 3'd1;
      else if (s2[1]) sel = 3'd2;
      else if (s2[2]) sel = 3'd3;
      else if (s2[3]) sel = 3'd4;
   end

   // Timer restarts whenever the held button being tracked changes
   assign same = (sel == sel_q);
   assign cur  = same ? cnt : '0;
   assign ph   = same & phase;
   assign fire = (sel != 3'd0) &&
                 (ph ? (cur == TW'(REPEAT_CYCLES)) : (cur == TW'(HOLD_CYCLES)));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         phase <= 1'b0;
         sel_q <= 3'd0;
      end else begin
         sel_q <= sel;
         if (sel == 3'd0) begin
            cnt   <= '0;
            phase <= 1'b0;
         end else if (fire) begin
            cnt   <= TW'(1);
            phase <= 1'b1;
         end else begin
            cnt   <= cur + TW'(1);
            phase <= ph;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 4; i++) rep[i] = fire && (sel == 3'(i + 1));
   end

   assign cmd = press | rep;

   always_comb begin
      cmd_dir = 2'd0;
      if (cmd[0])      cmd_dir = 2'd0;
      else if (cmd[1]) cmd_dir = 2'd2;
      else if (cmd[2]) cmd_dir = 2'd3;
      else if (cmd[3]) cmd_dir = 2'd1;
   end

   // Edge test gates each wall lookup so a wrapped index is never used
   always_comb begin
      vu      = VW'((int'(row) - 1) * COLS + int'(col));
      vd      = VW'(int'(row) * COLS + int'(col));
      hl      = HW'(int'(row) * (COLS - 1) + int'(col) - 1);
      hr      = HW'(int'(row) * (COLS - 1) + int'(col));
      blocked = 1'b1;
      mv_row  = row;
      mv_col  = col;
      unique case (cap_dir)
         2'd0: if (row != '0 && !walls_v[vu]) begin
            blocked = 1'b0;
            mv_row  = row - RW'(1);
         end
         2'd1: if (col != CW'(COLS - 1) && !walls_h[hr]) begin
            blocked = 1'b0;
            mv_col  = col + CW'(1);
         end
         2'd2: if (row != RW'(ROWS - 1) && !walls_v[vd]) begin
            blocked = 1'b0;
            mv_row  = row + RW'(1);
         end
         2'd3: if (col != '0 && !walls_h[hl]) begin
            blocked = 1'b0;
            mv_col  = col - CW'(1);
         end
      endcase
   end

   always_comb begin
      state_n  = state;
      cap_n    = cap_dir;
      row_n    = row;
      col_n    = col;
      dir_n    = direction;
      moved_n  = 1'b0;
      bumped_n = 1'b0;
      cnt_n    = move_count;
      if (restart) begin
         state_n = IDLE;
         row_n   = RW'(START_ROW);
         col_n   = CW'(START_COL);
         cnt_n   = '0;
      end else begin
         unique case (state)
            IDLE: if (enable && cmd != 4'd0) begin
               cap_n   = cmd_dir;
               state_n = EVAL;
            end
            EVAL: begin
               dir_n   = cap_dir;
               state_n = IDLE;
               if (blocked) begin
                  bumped_n = 1'b1;
               end else begin
                  moved_n = 1'b1;
                  row_n   = mv_row;
                  col_n   = mv_col;
                  if (~&move_count) cnt_n = move_count + CNT_W'(1);
                  if (mv_row == RW'(GOAL_ROW) && mv_col == CW'(GOAL_COL))
                     state_n = LOCKED;
               end
            end
            LOCKED: state_n = LOCKED;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cap_dir    <= 2'd0;
         row        <= RW'(START_ROW);
         col        <= CW'(START_COL);
         direction  <= 2'd0;
         moved      <= 1'b0;
         bumped     <= 1'b0;
         move_count <= '0;
      end else begin
         state      <= state_n;
         cap_dir    <= cap_n;
         row        <= row_n;
         col        <= col_n;
         direction  <= dir_n;
         moved      <= moved_n;
         bumped     <= bumped_n;
         move_count <= cnt_n;
      end
   end

   assign position = POS_W'(int'(row) * COLS + int'(col));
   assign at_goal  = (state == LOCKED);

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Scoreboard bench for maze_player_ctrl: expected move/bump events are
// queued at stimulus time and matched against moved/bumped pulses.
module tb_maze_player_ctrl;

   localparam int COLS = 6;
   localparam int ROWS = 5;

   logic                     clk = 1'b0;
   logic                     reset, btnU, btnD, btnL, btnR, enable, restart;
   logic [ROWS*(COLS-1)-1:0] walls_h;
   logic [(ROWS-1)*COLS-1:0] walls_v;
   logic [4:0]               position;
   logic [2:0]               row;
   logic [2:0]               col;
   logic [1:0]               direction;
   logic                     moved, bumped, at_goal;
   logic [9:0]               move_count;

   maze_player_ctrl #(
      .COLS(COLS), .ROWS(ROWS), .POS_W(5), .START_POS(0), .GOAL_POS(29),
      .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(10)
   ) dut (
      .clk(clk), .reset(reset),
      .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
      .enable(enable), .restart(restart),
      .walls_h(walls_h), .walls_v(walls_v),
      .position(position), .row(row), .col(col),
      .direction(direction), .moved(moved), .bumped(bumped),
      .at_goal(at_goal), .move_count(move_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit mv;
      int pos;
      int dir;
      int cnt;
   } ev_t;

   ev_t exq[$];
   int  evc[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_pass = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic expect_evt(input bit mv, input int pos, input int dir, input int cnt);
      ev_t e;
      e.mv  = mv;
      e.pos = pos;
      e.dir = dir;
      e.cnt = cnt;
      exq.push_back(e);
   endtask

   always @(negedge clk) begin
      ev_t e;
      if (!reset && (moved || bumped)) begin
         evc.push_back(cyc);
         if (exq.size() == 0) begin
            check("unexpected_evt", 1, 0);
         end else begin
            e = exq.pop_front();
            check("evt_moved", int'(moved), int'(e.mv));
            check("evt_bumped", int'(bumped), int'(!e.mv));
            check("evt_pos", int'(position), e.pos);
            check("evt_dir", int'(direction), e.dir);
            check("evt_cnt", int'(move_count), e.cnt);
         end
      end
   end

   // b = {R, L, D, U}
   task automatic push_btn(input logic [3:0] b, input int n);
      @(posedge clk);
      #1 {btnR, btnL, btnD, btnU} = b;
      repeat (n) @(posedge clk);
      #1 {btnR, btnL, btnD, btnU} = 4'b0000;
   endtask

   task automatic drain(input string tag, input int lim);
      int k = 0;
      while (exq.size() != 0 && k < lim) begin
         @(negedge clk);
         k++;
      end
      check(tag, exq.size(), 0);
      exq.delete();
      repeat (5) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      {btnR, btnL, btnD, btnU} = 4'b0000;
      enable  = 1'b1;
      restart = 1'b0;
      walls_h = '0;
      walls_v = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_pos", int'(position), 0);
      check("rst_row", int'(row), 0);
      check("rst_col", int'(col), 0);
      check("rst_dir", int'(direction), 0);
      check("rst_moved", int'(moved), 0);
      check("rst_bumped", int'(bumped), 0);
      check("rst_goal", int'(at_goal), 0);
      check("rst_cnt", int'(move_count), 0);

      // single right move
      expect_evt(1, 1, 1, 1);
      push_btn(4'b1000, 3);
      drain("t1_drain", 20);
      check("t1_col", int'(col), 1);

      // edge bumps and a horizontal wall
      expect_evt(1, 0, 3, 2);
      push_btn(4'b0100, 3);
      drain("t2_left", 20);
      expect_evt(0, 0, 0, 2);
      push_btn(4'b0001, 3);
      drain("t2_up_edge", 20);
      expect_evt(0, 0, 3, 2);
      push_btn(4'b0100, 3);
      drain("t2_left_edge", 20);
      walls_h[0] = 1'b1;
      expect_evt(0, 0, 1, 2);
      push_btn(4'b1000, 3);
      drain("t2_wall_h", 20);
      walls_h = '0;

      // simultaneous up+right at row 1: up wins
      expect_evt(1, 6, 2, 3);
      push_btn(4'b0010, 3);
      drain("t3_down", 20);
      expect_evt(1, 0, 0, 4);
      push_btn(4'b1001, 3);
      drain("t3_prio", 20);

      // held down with auto-repeat, then bumps at the bottom edge
      evc.delete();
      expect_evt(1, 6, 2, 5);
      expect_evt(1, 12, 2, 6);
      expect_evt(1, 18, 2, 7);
      expect_evt(1, 24, 2, 8);
      expect_evt(0, 24, 2, 8);
      expect_evt(0, 24, 2, 8);
      push_btn(4'b0010, 26);
      drain("t4_drain", 40);
      check("t4_nevt", evc.size(), 6);
      if (evc.size() >= 4) begin
         check("t4_hold_gap", evc[1] - evc[0], 8);
         check("t4_rep_gap1", evc[2] - evc[1], 4);
         check("t4_rep_gap2", evc[3] - evc[2], 4);
      end

      // walk to the goal and lock
      for (int i = 1; i <= 5; i++) begin
         expect_evt(1, 24 + i, 1, 8 + i);
         push_btn(4'b1000, 3);
         drain("t5_walk", 20);
      end
      check("t5_goal", int'(at_goal), 1);
      push_btn(4'b0100, 3);
      repeat (10) @(negedge clk);
      check("t5_lock_pos", int'(position), 29);
      check("t5_lock_goal", int'(at_goal), 1);
      check("t5_lock_cnt", int'(move_count), 13);
      @(posedge clk);
      #1 restart = 1'b1;
      @(posedge clk);
      #1 restart = 1'b0;
      check("t5_rs_pos", int'(position), 0);
      check("t5_rs_goal", int'(at_goal), 0);
      check("t5_rs_cnt", int'(move_count), 0);

      // enable low ignores commands
      enable = 1'b0;
      push_btn(4'b1000, 3);
      repeat (10) @(negedge clk);
      check("en_pos", int'(position), 0);
      enable = 1'b1;

      // vertical wall, then a legal move
      walls_v[0] = 1'b1;
      expect_evt(0, 0, 2, 0);
      push_btn(4'b0010, 3);
      drain("wv_bump", 20);
      walls_v = '0;
      expect_evt(1, 1, 1, 1);
      push_btn(4'b1000, 3);
      drain("wv_move", 20);

      // reset spanning the evaluation of a legal right move
      @(posedge clk);
      #1 btnR = 1'b1;
      repeat (3) @(posedge clk);
      #1 begin
         reset = 1'b1;
         btnR  = 1'b0;
      end
      @(posedge clk);
      #1;
      check("t6_moved", int'(moved), 0);
      check("t6_pos_a", int'(position), 0);
      @(posedge clk);
      #1;
      check("t6_pos", int'(position), 0);
      check("t6_cnt", int'(move_count), 0);
      check("t6_dir", int'(direction), 0);
      check("t6_moved_b", int'(moved), 0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      check("t6_after", int'(position), 0);
      check("end_queue", exq.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
